// File: rtl/uart_bus_responder_pkg.sv
// ============================================================================
// Module : uart_bus_responder_pkg
// Brief  : Shared UART state encodings and default bit timing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_bus_responder_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        UART_FSM_IDLE  = 2'd0,
        UART_FSM_START = 2'd1,
        UART_FSM_DATA  = 2'd2,
        UART_FSM_STOP  = 2'd3
    } uart_fsm_e;

endpackage

`default_nettype wire

// File: rtl/uart_bus_responder_rx_deser.sv
// ============================================================================
// Module : uart_rx_deser
// Brief  : 8N1 receiver: rxd synchroniser, RX FSM and shift register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_deser
    import uart_bus_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    uart_fsm_e   state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic        prev_q, prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        rx_s;
    logic        fall;

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rxd};
        prev_d  = rx_s;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        case (state_q)
            UART_FSM_IDLE: begin
                if (fall) begin
                    cnt_d   = 16'd0;
                    state_d = UART_FSM_START;
                end
            end
            UART_FSM_START: begin
                // Mid-start sample rejects glitches shorter than half a bit.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        state_d = UART_FSM_IDLE;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = UART_FSM_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            UART_FSM_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = UART_FSM_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            UART_FSM_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = UART_FSM_IDLE;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = UART_FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UART_FSM_IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            byte_q  <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/uart_bus_responder.sv
// ============================================================================
// Module : uart_bus_responder
// Brief  : In-FPGA UART responding to the ram_uart strobe handshake; TX path here.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_bus_responder
    import uart_bus_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdn,
    input  logic       wrn,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_overrun,
    output logic       tx_drop
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic        rdn_q, wrn_q;
    uart_fsm_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  thr_q, thr_d;
    logic [7:0]  tsr_q, tsr_d;
    logic [7:0]  rbr_q, rbr_d;
    logic        tbre_q, tbre_d;
    logic        tsre_q, tsre_d;
    logic        txd_q, txd_d;
    logic        data_ready_q, data_ready_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        tx_drop_q, tx_drop_d;
    logic        rdn_rise, wrn_rise;
    logic [7:0]  rx_byte;
    logic        rx_valid;

    uart_rx_deser #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst),
        .rxd      (rxd),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    assign rdn_rise = ~rdn_q & rdn;
    assign wrn_rise = ~wrn_q & wrn;

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_idx_d     = tx_idx_q;
        thr_d        = thr_q;
        tsr_d        = tsr_q;
        rbr_d        = rbr_q;
        tbre_d       = tbre_q;
        tsre_d       = tsre_q;
        txd_d        = txd_q;
        data_ready_d = data_ready_q;
        rx_overrun_d = 1'b0;
        tx_drop_d    = 1'b0;

        if (wrn_rise) begin
            if (tbre_q) begin
                thr_d  = bus_din;
                tbre_d = 1'b0;
            end else begin
                tx_drop_d = 1'b1;
            end
        end

        if (rdn_rise) begin
            data_ready_d = 1'b0;
        end
        // A byte landing on the read edge wins; the byte being read is not lost.
        if (rx_valid) begin
            rbr_d        = rx_byte;
            data_ready_d = 1'b1;
            rx_overrun_d = data_ready_q & ~rdn_rise;
        end

        // THR loads only when tbre=0, the bus write only when tbre=1: never both.
        case (tx_state_q)
            UART_FSM_IDLE: begin
                if (!tbre_q) begin
                    tsr_d      = thr_q;
                    tbre_d     = 1'b1;
                    tsre_d     = 1'b0;
                    txd_d      = 1'b0;
                    tx_cnt_d   = 16'd0;
                    tx_state_d = UART_FSM_START;
                end
            end
            UART_FSM_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_idx_d   = 3'd0;
                    txd_d      = tsr_q[0];
                    tx_state_d = UART_FSM_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            UART_FSM_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = 16'd0;
                    if (tx_idx_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = UART_FSM_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        tsr_d    = tsr_q >> 1;
                        txd_d    = tsr_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            UART_FSM_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = 16'd0;
                    if (!tbre_q) begin
                        tsr_d      = thr_q;
                        tbre_d     = 1'b1;
                        txd_d      = 1'b0;
                        tx_state_d = UART_FSM_START;
                    end else begin
                        tsre_d     = 1'b1;
                        tx_state_d = UART_FSM_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = UART_FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdn_q        <= 1'b1;
            wrn_q        <= 1'b1;
            tx_state_q   <= UART_FSM_IDLE;
            tx_cnt_q     <= 16'd0;
            tx_idx_q     <= 3'd0;
            thr_q        <= 8'd0;
            tsr_q        <= 8'd0;
            rbr_q        <= 8'd0;
            tbre_q       <= 1'b1;
            tsre_q       <= 1'b1;
            txd_q        <= 1'b1;
            data_ready_q <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
        end else begin
            rdn_q        <= rdn;
            wrn_q        <= wrn;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            thr_q        <= thr_d;
            tsr_q        <= tsr_d;
            rbr_q        <= rbr_d;
            tbre_q       <= tbre_d;
            tsre_q       <= tsre_d;
            txd_q        <= txd_d;
            data_ready_q <= data_ready_d;
            rx_overrun_q <= rx_overrun_d;
            tx_drop_q    <= tx_drop_d;
        end
    end

    assign bus_oe     = ~rdn;
    assign bus_dout   = rbr_q;
    assign data_ready = data_ready_q;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign txd        = txd_q;
    assign rx_overrun = rx_overrun_q;
    assign tx_drop    = tx_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_responder.sv
// ============================================================================
// Module : tb_uart_bus_responder
// Brief  : Scoreboard bench for uart_bus_responder at 16 clocks per bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_bus_responder;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] bus_din = 8'd0;
    logic [7:0] bus_dout;
    logic       bus_oe, data_ready, tbre, tsre, txd, rx_overrun, tx_drop;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rst_gen = 0;
    int ovr_cnt = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int tx_starts[$];

    uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdn        (rdn),
        .wrn        (wrn),
        .bus_din    (bus_din),
        .bus_dout   (bus_dout),
        .bus_oe     (bus_oe),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .txd        (txd),
        .rxd        (rxd),
        .rx_overrun (rx_overrun),
        .tx_drop    (tx_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt++;

    // Decodes every txd frame mid-bit and scores it against tx_exp.
    initial begin : tx_monitor
        int g, st;
        logic [7:0] b, e;
        logic s0, sb;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && txd === 1'b0) begin
                g  = rst_gen;
                st = cyc;
                repeat (CPB / 2) @(negedge clk);
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                sb = txd;
                if (g == rst_gen) begin
                    tx_starts.push_back(st);
                    checks++;
                    if (tx_exp.size() == 0) begin
                        errors++;
                        $display("FAIL tx_frame unexpected frame got %02h expected none", b);
                    end else begin
                        e = tx_exp.pop_front();
                        if (b !== e || s0 !== 1'b0 || sb !== 1'b1) begin
                            errors++;
                            $display("FAIL tx_frame got %02h start %b stop %b expected %02h start 0 stop 1",
                                     b, s0, sb, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic write_byte(input logic [7:0] d, input bit accept);
        @(posedge clk); #1 wrn = 1'b0; bus_din = d;
        @(posedge clk); #1 wrn = 1'b1;
        if (accept) tx_exp.push_back(d);
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        if (stop) rx_exp.push_back(d);
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        drive_bit(1'b1);
    endtask

    task automatic read_check(input string name);
        logic [7:0] e;
        @(posedge clk); #1 rdn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_oe !== 1'b1) begin
            errors++; $display("FAIL %s bus_oe got %b expected 1", name, bus_oe);
        end
        checks++;
        if (rx_exp.size() == 0) begin
            errors++; $display("FAIL %s no expected rx byte queued, bus_dout %02h", name, bus_dout);
        end else begin
            e = rx_exp.pop_front();
            if (bus_dout !== e) begin
                errors++; $display("FAIL %s bus_dout got %02h expected %02h", name, bus_dout, e);
            end
        end
        @(posedge clk); #1 rdn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b0 || bus_oe !== 1'b0) begin
            errors++; $display("FAIL %s after read data_ready %b bus_oe %b expected 0 0", name, data_ready, bus_oe);
        end
    endtask

    task automatic wait_tsre(input string name);
        int n = 0;
        while (tsre !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tsre !== 1'b1) begin
            errors++; $display("FAIL %s tsre wait timeout got %b expected 1", name, tsre);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tbre, tsre, data_ready, txd, bus_oe} !== 5'b11010) begin
            errors++; $display("FAIL reset flags tbre/tsre/dr/txd/oe got %b expected 11010",
                               {tbre, tsre, data_ready, txd, bus_oe});
        end
        checks++;
        if (bus_dout !== 8'h00 || rx_overrun !== 1'b0 || tx_drop !== 1'b0) begin
            errors++; $display("FAIL reset outputs bus_dout %02h ovr %b drop %b expected 00 0 0",
                               bus_dout, rx_overrun, tx_drop);
        end
    endtask

    task automatic test_tx_single();
        write_byte(8'hA5, 1'b1);
        @(negedge clk);
        checks++;
        if (tbre !== 1'b1) begin errors++; $display("FAIL tx_tbre_n got %b expected 1", tbre); end
        @(negedge clk);
        checks++;
        if (tbre !== 1'b0 || txd !== 1'b1) begin
            errors++; $display("FAIL tx_n1 tbre %b txd %b expected 0 1", tbre, txd);
        end
        @(negedge clk);
        checks++;
        if (tbre !== 1'b1 || txd !== 1'b0 || tsre !== 1'b0) begin
            errors++; $display("FAIL tx_n2 tbre %b txd %b tsre %b expected 1 0 0", tbre, txd, tsre);
        end
        repeat (159) @(negedge clk);
        checks++;
        if (tsre !== 1'b0) begin errors++; $display("FAIL tx_tsre_late got %b expected 0", tsre); end
        @(negedge clk);
        checks++;
        if (tsre !== 1'b1 || txd !== 1'b1) begin
            errors++; $display("FAIL tx_tsre_end tsre %b txd %b expected 1 1", tsre, txd);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        tx_starts.delete();
        write_byte(8'h55, 1'b1);
        repeat (2) @(negedge clk);
        while (tbre !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        write_byte(8'h0F, 1'b1);
        write_byte(8'h99, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tx_drop !== 1'b1) begin errors++; $display("FAIL tx_drop pulse got %b expected 1", tx_drop); end
        @(negedge clk);
        checks++;
        if (tx_drop !== 1'b0) begin errors++; $display("FAIL tx_drop width got %b expected 0", tx_drop); end
        wait_tsre("b2b");
        checks++;
        if (tx_starts.size() != 2) begin
            errors++; $display("FAIL b2b frame count got %0d expected 2", tx_starts.size());
        end else if (tx_starts[1] - tx_starts[0] != 10 * CPB) begin
            errors++; $display("FAIL b2b gap got %0d expected %0d", tx_starts[1] - tx_starts[0], 10 * CPB);
        end
        checks++;
        if (tx_exp.size() != 0) begin
            errors++; $display("FAIL b2b pending tx bytes got %0d expected 0", tx_exp.size());
        end
    endtask

    task automatic test_rx_basic();
        send_frame(8'h3C, 1'b1);
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL rx_ready got %b expected 1", data_ready); end
        read_check("rx_3c");
    endtask

    task automatic test_rx_errors();
        int o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checks++;
        if (ovr_cnt - o0 != 1) begin
            errors++; $display("FAIL rx_overrun pulses got %0d expected 1", ovr_cnt - o0);
        end
        void'(rx_exp.pop_front());
        read_check("rx_overrun_22");
        @(posedge clk); #1 rxd = 1'b0;
        repeat (8) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL rx_glitch data_ready got %b expected 0", data_ready); end
        send_frame(8'hC5, 1'b0);
        repeat (CPB) @(posedge clk);
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL rx_framing data_ready got %b expected 0", data_ready); end
        send_frame(8'h5A, 1'b1);
        read_check("rx_after_errors");
    endtask

    task automatic test_reset_mid();
        write_byte(8'hC3, 1'b0);
        repeat (30) @(posedge clk);
        #1 rxd = 1'b0;
        repeat (44) @(posedge clk);
        #1 rst = 1'b0;
        rst_gen++;
        #1;
        checks++;
        if ({txd, tbre, tsre, data_ready, bus_oe} !== 5'b11100) begin
            errors++; $display("FAIL reset_mid txd/tbre/tsre/dr/oe got %b expected 11100",
                               {txd, tbre, tsre, data_ready, bus_oe});
        end
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b0 || txd !== 1'b1) begin
            errors++; $display("FAIL reset_mid after data_ready %b txd %b expected 0 1", data_ready, txd);
        end
        write_byte(8'h96, 1'b1);
        repeat (4) @(negedge clk);
        wait_tsre("reset_mid_tx");
        send_frame(8'hE7, 1'b1);
        read_check("reset_mid_rx");
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_basic();
        test_rx_errors();
        test_reset_mid();
        repeat (20) @(negedge clk);
        checks++;
        if (tx_exp.size() != 0 || rx_exp.size() != 0) begin
            errors++; $display("FAIL final queues tx %0d rx %0d expected 0 0", tx_exp.size(), rx_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
